// File: rtl/spram32_arb.sv
// spram32_arb: round-robin arbiter sharing one single-port 32-bit memory between two masters, with capped locked bursts
module spram32_arb #(
  parameter int ASZ = 15,
  parameter int DSZ = 32,
  parameter int BURST_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_req,
  input  logic           a_we,
  input  logic [ASZ-1:0] a_ai,
  input  logic [DSZ-1:0] a_vi,
  input  logic [3:0]     a_bmsk,
  input  logic           a_lock,
  output logic           a_gnt,
  output logic [DSZ-1:0] a_vo,
  output logic           a_rvld,
  input  logic           b_req,
  input  logic           b_we,
  input  logic [ASZ-1:0] b_ai,
  input  logic [DSZ-1:0] b_vi,
  input  logic [3:0]     b_bmsk,
  input  logic           b_lock,
  output logic           b_gnt,
  output logic [DSZ-1:0] b_vo,
  output logic           b_rvld,
  output logic [ASZ-1:0] m_ai,
  output logic           m_we,
  output logic [DSZ-1:0] m_vi,
  output logic [3:0]     m_bmsk,
  input  logic [DSZ-1:0] m_vo
);
  localparam int CW = $clog2(BURST_MAX + 1);
  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} st_t;
  st_t st;
  logic last;
  logic [CW-1:0] cnt;
  logic hold_a, hold_b, cap, idle_a;
  always_comb begin
    hold_a = st == LOCK_A && a_req && a_lock;
    hold_b = st == LOCK_B && b_req && b_lock;
    cap    = cnt == CW'(BURST_MAX);
    idle_a = a_req && (!b_req || last);
    a_gnt  = hold_a ? !(b_req && cap) : hold_b ? (a_req && cap) : idle_a;
    b_gnt  = hold_b ? !(a_req && cap) : hold_a ? (b_req && cap) : (b_req && !idle_a);
    m_ai   = a_gnt ? a_ai : b_gnt ? b_ai : '0;
    m_we   = a_gnt ? a_we : b_gnt ? b_we : 1'b0;
    m_vi   = a_gnt ? a_vi : b_gnt ? b_vi : '0;
    m_bmsk = (a_gnt && a_we) ? a_bmsk : (b_gnt && b_we) ? b_bmsk : 4'h0;
  end
  assign a_vo = m_vo;
  assign b_vo = m_vo;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      last   <= 1'b1;
      cnt    <= '0;
      a_rvld <= 1'b0;
      b_rvld <= 1'b0;
    end else begin
      a_rvld <= a_gnt & ~a_we;
      b_rvld <= b_gnt & ~b_we;
      if (a_gnt) last <= 1'b0;
      else if (b_gnt) last <= 1'b1;
      if ((a_gnt && hold_a) || (b_gnt && hold_b)) cnt <= cap ? cnt : cnt + 1'b1;
      else if (a_gnt && a_lock) begin
        st  <= LOCK_A;
        cnt <= CW'(1);
      end else if (b_gnt && b_lock) begin
        st  <= LOCK_B;
        cnt <= CW'(1);
      end else begin
        st  <= IDLE;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_spram32_arb.sv
// tb_spram32_arb: random and directed stimulus against a behavioural arbiter/memory model
module tb_spram32_arb;
  localparam int BM = 8;
  logic clk = 0, rst = 1;
  logic a_req = 0, a_we = 0, a_lock = 0, b_req = 0, b_we = 0, b_lock = 0;
  logic [14:0] a_ai = 0, b_ai = 0;
  logic [31:0] a_vi = 0, b_vi = 0;
  logic [3:0] a_bmsk = 0, b_bmsk = 0;
  logic a_gnt, b_gnt, a_rvld, b_rvld, m_we;
  logic [31:0] a_vo, b_vo, m_vi, m_vo;
  logic [14:0] m_ai;
  logic [3:0] m_bmsk;
  int checks = 0, errors = 0;

  spram32_arb #(.ASZ(15), .DSZ(32), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_ai(a_ai), .a_vi(a_vi), .a_bmsk(a_bmsk), .a_lock(a_lock),
    .a_gnt(a_gnt), .a_vo(a_vo), .a_rvld(a_rvld),
    .b_req(b_req), .b_we(b_we), .b_ai(b_ai), .b_vi(b_vi), .b_bmsk(b_bmsk), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_vo(b_vo), .b_rvld(b_rvld),
    .m_ai(m_ai), .m_we(m_we), .m_vi(m_vi), .m_bmsk(m_bmsk), .m_vo(m_vo)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  logic [31:0] smem [int];
  always @(posedge clk) begin
    m_vo <= smem.exists(int'(m_ai)) ? smem[int'(m_ai)] : 32'h0;
    if (m_we) smem[int'(m_ai)] = merge(smem.exists(int'(m_ai)) ? smem[int'(m_ai)] : 32'h0, m_vi, m_bmsk);
  end

  logic [31:0] mmem [int];
  int w, own = 0, lastp = 2, run = 0;
  logic hown, pa = 0, pb = 0, ewe, wlock;
  logic [14:0] eai;
  logic [31:0] evi, pd = 0, old;
  logic [3:0] emsk;
  always @(negedge clk) begin
    if (rst) begin
      own = 0;
      lastp = 2;
      run = 0;
    end
    hown = (own == 1 && a_req && a_lock) || (own == 2 && b_req && b_lock);
    if (own == 1 && hown) w = (b_req && run == BM) ? 2 : 1;
    else if (own == 2 && hown) w = (a_req && run == BM) ? 1 : 2;
    else if (a_req && b_req) w = (lastp == 1) ? 2 : 1;
    else w = a_req ? 1 : b_req ? 2 : 0;
    ewe   = w == 1 ? a_we : w == 2 ? b_we : 1'b0;
    eai   = w == 1 ? a_ai : w == 2 ? b_ai : 15'h0;
    evi   = w == 1 ? a_vi : w == 2 ? b_vi : 32'h0;
    emsk  = !ewe ? 4'h0 : w == 1 ? a_bmsk : b_bmsk;
    wlock = w == 1 ? a_lock : w == 2 ? b_lock : 1'b0;
    chk("a_gnt", 32'(a_gnt), 32'(w == 1));
    chk("b_gnt", 32'(b_gnt), 32'(w == 2));
    chk("m_ai", 32'(m_ai), 32'(eai));
    chk("m_we", 32'(m_we), 32'(ewe));
    chk("m_vi", m_vi, evi);
    chk("m_bmsk", 32'(m_bmsk), 32'(emsk));
    chk("a_rvld", 32'(a_rvld), 32'(!rst && pa));
    chk("b_rvld", 32'(b_rvld), 32'(!rst && pb));
    if (!rst && pa) chk("a_vo", a_vo, pd);
    if (!rst && pb) chk("b_vo", b_vo, pd);
    old = mmem.exists(int'(eai)) ? mmem[int'(eai)] : 32'h0;
    if (w != 0 && ewe) mmem[int'(eai)] = merge(old, evi, emsk);
    if (w != 0 && !ewe) pd = old;
    pa = !rst && w == 1 && !a_we;
    pb = !rst && w == 2 && !b_we;
    if (!rst) begin
      if (w != 0) lastp = w;
      if (w != 0 && hown && w == own) run = run < BM ? run + 1 : BM;
      else if (w != 0 && wlock) begin
        own = w;
        run = 1;
      end else begin
        own = 0;
        run = 0;
      end
    end
  end

  task automatic go;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ms [3];
  logic [31:0] ev [3];

  initial begin
    ms = '{4'hF, 4'h7, 4'h3};
    ev = '{32'hFFFF_FFFF, 32'h00FF_FFFF, 32'h0000_FFFF};
    @(negedge clk);
    chk("rst a_gnt", 32'(a_gnt), 0);
    chk("rst b_gnt", 32'(b_gnt), 0);
    chk("rst rvld", 32'({a_rvld, b_rvld}), 0);
    chk("rst m_we", 32'(m_we), 0);
    go;
    rst = 0;
    for (int i = 0; i < 15; i++) begin
      a_req = 1; a_we = 1; a_ai = 15'(i); a_vi = 32'h1 | i; a_bmsk = 4'hF;
      @(negedge clk);
      chk("wr a_gnt", 32'(a_gnt), 1);
      go;
    end
    for (int i = 0; i < 16; i++) begin
      a_we = 0; a_ai = 15'(i); a_req = i < 15;
      @(negedge clk);
      if (i < 15) chk("rd a_gnt", 32'(a_gnt), 1);
      if (i > 0) begin
        chk("rd a_rvld", 32'(a_rvld), 1);
        chk("rd a_vo", a_vo, 32'h1 | (i - 1));
        chk("rd b_rvld", 32'(b_rvld), 0);
      end
      go;
    end
    rst = 1;
    go;
    rst = 0; a_req = 1; b_req = 1; a_we = 0; b_we = 0; b_ai = 15'h3;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr a_gnt", 32'(a_gnt), 32'(k % 2 == 0));
      chk("rr b_gnt", 32'(b_gnt), 32'(k % 2 == 1));
      go;
    end
    b_req = 0;
    @(negedge clk);
    go;
    b_req = 1; b_lock = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("burst a_gnt", 32'(a_gnt), 32'(k == 8));
      chk("burst b_gnt", 32'(b_gnt), 32'(k != 8));
      go;
    end
    b_req = 0; b_lock = 0;
    for (int j = 0; j < 3; j++) begin
      a_req = 1; a_we = 1; a_ai = 15'h7FFF; a_vi = 32'h0; a_bmsk = 4'hF;
      @(negedge clk);
      go;
      a_vi = 32'hFFFF_FFFF; a_bmsk = ms[j];
      @(negedge clk);
      go;
      a_we = 0;
      @(negedge clk);
      go;
      a_req = 0;
      @(negedge clk);
      chk("mask a_vo", a_vo, ev[j]);
      go;
    end
    a_req = 1; a_we = 1; a_ai = 15'h1F; a_vi = 32'hA5A5_001F; a_bmsk = 4'hF;
    @(negedge clk);
    go;
    a_req = 0; b_req = 1; b_we = 1; b_ai = 15'h20; b_vi = 32'h5A5A_0020; b_bmsk = 4'hF;
    @(negedge clk);
    go;
    b_req = 0; a_req = 1; a_we = 0;
    @(negedge clk);
    go;
    a_req = 0; b_req = 1; b_we = 0;
    @(negedge clk);
    chk("il a_rvld", 32'(a_rvld), 1);
    chk("il b_rvld", 32'(b_rvld), 0);
    chk("il a_vo", a_vo, 32'hA5A5_001F);
    go;
    b_req = 0;
    @(negedge clk);
    chk("il a_rvld2", 32'(a_rvld), 0);
    chk("il b_rvld2", 32'(b_rvld), 1);
    chk("il b_vo", b_vo, 32'h5A5A_0020);
    go;
    a_req = 1; a_lock = 1; a_we = 0; a_ai = 15'h5;
    @(negedge clk);
    go;
    @(negedge clk);
    chk("lk a_gnt", 32'(a_gnt), 1);
    go;
    a_req = 0; a_lock = 0; rst = 1;
    @(negedge clk);
    chk("rst a_rvld", 32'(a_rvld), 0);
    go;
    rst = 0; a_req = 1; b_req = 1;
    @(negedge clk);
    chk("post-rst a_gnt", 32'(a_gnt), 1);
    chk("post-rst b_gnt", 32'(b_gnt), 0);
    go;
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 199) == 0;
      a_req = $urandom_range(0, 3) != 0; b_req = $urandom_range(0, 3) != 0;
      a_we = 1'($urandom); b_we = 1'($urandom);
      a_lock = $urandom_range(0, 3) != 0; b_lock = $urandom_range(0, 3) != 0;
      a_ai = $urandom_range(0, 9) == 0 ? 15'h7FFF : 15'($urandom_range(0, 15));
      b_ai = $urandom_range(0, 9) == 0 ? 15'h7FFF : 15'($urandom_range(0, 15));
      a_vi = $urandom; b_vi = $urandom;
      a_bmsk = 4'($urandom); b_bmsk = 4'($urandom);
      @(negedge clk);
      go;
    end
    rst = 0; a_req = 0; b_req = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
